data_memory_arbiter: RTL

//  Shares the single-port data memory between two requesters: port 0 (core load/store) and port 1 (init/debug loader).

---
 rtl/data_memory_arbiter_if.sv | 28 ++
 rtl/data_memory_arbiter.sv | 124 ++++++++++++
 2 files changed

// File: rtl/data_memory_arbiter_if.sv
// Requester-side bundle of the data memory arbiter: two request/ack ports with address, data and read-back.
interface data_memory_arbiter_if #(
    parameter int unsigned WORDSIZE   = 64,
    parameter int unsigned ADDR_WIDTH = 5
);
    logic                  req0;
    logic                  req1;
    logic                  we0;
    logic                  we1;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [WORDSIZE-1:0]   wdata0;
    logic [WORDSIZE-1:0]   wdata1;
    logic                  ack0;
    logic                  ack1;
    logic [WORDSIZE-1:0]   rdata0;
    logic [WORDSIZE-1:0]   rdata1;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  ack0, ack1, rdata0, rdata1
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output ack0, ack1, rdata0, rdata1
    );
endinterface

// File: rtl/data_memory_arbiter.sv
// Two-requester arbiter for the single-port data memory, one access per three cycles.
// Define DMEM_ARB_FIXED_PRIORITY_EN to make port 0 win every tie (default: round-robin).
module data_memory_arbiter #(
    parameter int unsigned WORDSIZE   = 64,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    data_memory_arbiter_if.slave  bus,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [WORDSIZE-1:0]   mem_wdata_o,
    output logic                  mem_we_o,
    output logic                  mem_re_o,
    input  logic [WORDSIZE-1:0]   mem_rdata_i,
    output logic [CNT_WIDTH-1:0]  gcnt0_o,
    output logic [CNT_WIDTH-1:0]  gcnt1_o
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

    state_e                state_q, state_d;
    logic                  gid_q, gid_d;
    logic                  last_grant_q, last_grant_d;
    logic                  ack0_q, ack0_d, ack1_q, ack1_d;
    logic [WORDSIZE-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic [CNT_WIDTH-1:0]  gcnt0_q, gcnt0_d, gcnt1_q, gcnt1_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [WORDSIZE-1:0]   mem_wdata_q, mem_wdata_d;
    logic                  mem_we_q, mem_we_d, mem_re_q, mem_re_d;

    // Next-state and output logic; memory pins are loaded on entry to ACCESS and cleared on exit.
    always_comb begin
        state_d      = state_q;
        gid_d        = gid_q;
        last_grant_d = last_grant_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        gcnt0_d      = gcnt0_q;
        gcnt1_d      = gcnt1_q;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;
        mem_we_d     = 1'b0;
        mem_re_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
`ifdef DMEM_ARB_FIXED_PRIORITY_EN
                    gid_d = ~bus.req0;
`else
                    gid_d = (bus.req0 && bus.req1) ? ~last_grant_q : bus.req1;
`endif
                    state_d     = ACCESS;
                    mem_addr_d  = gid_d ? bus.addr1  : bus.addr0;
                    mem_wdata_d = gid_d ? bus.wdata1 : bus.wdata0;
                    mem_we_d    = gid_d ? bus.we1    : bus.we0;
                    mem_re_d    = ~mem_we_d;
                end
            end
            ACCESS: begin
                state_d      = DONE;
                last_grant_d = gid_q;
                if (mem_re_q) begin
                    if (gid_q) rdata1_d = mem_rdata_i;
                    else       rdata0_d = mem_rdata_i;
                end
                ack0_d = ~gid_q;
                ack1_d = gid_q;
            end
            DONE: begin
                state_d = IDLE;
                if (!gid_q && !(&gcnt0_q)) gcnt0_d = gcnt0_q + CNT_WIDTH'(1);
                if ( gid_q && !(&gcnt1_q)) gcnt1_d = gcnt1_q + CNT_WIDTH'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            gid_q        <= 1'b0;
            last_grant_q <= 1'b1;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            gcnt0_q      <= '0;
            gcnt1_q      <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            mem_re_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            gid_q        <= gid_d;
            last_grant_q <= last_grant_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            gcnt0_q      <= gcnt0_d;
            gcnt1_q      <= gcnt1_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
            mem_re_q     <= mem_re_d;
        end
    end

    // Strobes are gated by reset so an access cut short by reset never reaches the memory.
    assign mem_we_o    = mem_we_q & rst_n;
    assign mem_re_o    = mem_re_q & rst_n;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign bus.ack0    = ack0_q;
    assign bus.ack1    = ack1_q;
    assign bus.rdata0  = rdata0_q;
    assign bus.rdata1  = rdata1_q;
    assign gcnt0_o     = gcnt0_q;
    assign gcnt1_o     = gcnt1_q;
endmodule
